dmem_arbiter: RTL and testbench
===============================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 12, meaning the data-memory word address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, meaning the data-memory data width.
REQ-003 SHALL have port sysclk  input  1  system clock; all state changes on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports mN_req  input  1  access request from requester N, N=0 (CPU load/store) and N=1 (debug/loader).
REQ-006 SHALL have ports mN_we  input  1  1=write, 0=read, for requester N.
REQ-007 SHALL have ports mN_rw_mode  input  2  access size for requester N (byte/half/word), passed through unchanged.
REQ-008 SHALL have ports mN_addr  input  ADDR_WIDTH  and  mN_wdata  input  DATA_WIDTH  for requester N.
REQ-009 SHALL have ports mN_gnt  output  1  one-cycle grant pulse: the command was issued to memory this cycle.
REQ-010 SHALL have ports mN_rvalid  output  1  and  mN_rdata  output  DATA_WIDTH  read-return for requester N.
REQ-011 SHALL have ports mem_wr_en  output  1,  mem_rw_mode  output  2,  mem_addr  output  ADDR_WIDTH,  mem_wdata  output  DATA_WIDTH  toward the single memory port.
REQ-012 SHALL have port mem_rdata  input  DATA_WIDTH  memory read data, valid exactly one cycle after the address is issued.

Function
REQ-013 SHALL implement states IDLE, ISSUE, RDWAIT, plus a registered owner bit (0 or 1).
REQ-014 IDLE: on a rising edge with any mN_req=1, SHALL pick a winner, load owner, go to ISSUE; with no request SHALL stay in IDLE.
REQ-015 ISSUE: SHALL drive mem_addr, mem_rw_mode, mem_wdata from the owner's inputs and assert m<owner>_gnt for exactly this one cycle.
REQ-016 ISSUE: mem_wr_en SHALL equal m<owner>_we; next state is RDWAIT on read, IDLE on write.
REQ-017 RDWAIT: SHALL assert m<owner>_rvalid for one cycle with m<owner>_rdata = mem_rdata, then go to IDLE.
REQ-018 Latency from req sampled in IDLE: gnt 1 cycle later; rvalid 2 cycles later; throughput one write per 2 cycles, one read per 3 cycles.
REQ-019 Outside ISSUE, mem_wr_en SHALL be 0 and mem_addr/mem_wdata/mem_rw_mode SHALL be 0.
REQ-020 mN_rdata SHALL be 0 whenever mN_rvalid=0; the non-owner's gnt and rvalid SHALL be 0.
REQ-021 A requester SHALL hold req, we, rw_mode, addr, wdata stable from assertion until its gnt cycle; the arbiter samples them only in ISSUE.
REQ-022 A req deasserted before grant (while the other owns the port) SHALL be ignored; no gnt is produced for it.
REQ-023 A req still asserted in the gnt cycle SHALL be treated as a new request at the next IDLE.
REQ-024 Simultaneous requests: winner per REQ-030/REQ-031; the loser waits with req held and SHALL be served at the next IDLE arbitration if still requesting.

Reset
REQ-025 While rst=0, state SHALL be IDLE, owner SHALL be 0, round-robin pointer (if present) SHALL point to requester 0.
REQ-026 While rst=0, all outputs SHALL be 0, including mem_wr_en, all gnt and all rvalid.
REQ-027 Reset asserted in ISSUE or RDWAIT SHALL abort the transaction immediately; no gnt or rvalid pulse SHALL follow it.
REQ-028 After rst rises, first arbitration SHALL occur on the first rising edge with a request.
REQ-029 The arbiter SHALL NOT issue a memory write during or in the cycle reset deasserts.

Configuration
REQ-030 Macro DMEM_ARB_RR_EN defined: round-robin; the pointer SHALL toggle to the non-winner after each grant; on contention the pointed-to requester wins.
REQ-031 DMEM_ARB_RR_EN undefined: fixed priority, requester 0 SHALL win every contention; no pointer register SHALL exist.

Verification
REQ-032 Reset mid-read: m0 read issued, rst=0 during RDWAIT -> no m0_rvalid, all outputs 0, IDLE after release.
REQ-033 Single write: m1_req=1, we=1, addr=0x010, wdata=0xDEADBEEF -> one cycle later m1_gnt=1, mem_wr_en=1, mem_addr=0x010, mem_wdata=0xDEADBEEF; back in IDLE next cycle.
REQ-034 Single read: m0 read addr=0x004, memory holds 0x12345678 -> gnt at +1, m0_rvalid=1 and m0_rdata=0x12345678 at +2, m1_rvalid=0.
REQ-035 Contention, fixed priority: m0_req=m1_req=1 held for 10 cycles, both writes -> only m0 granted every 2 cycles, m1 never granted.
REQ-036 Contention, DMEM_ARB_RR_EN defined: m0 and m1 reads held -> grants alternate m0, m1, m0, m1, one per 3 cycles, each rvalid routed to its own port only.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Two-requester arbiter (m0 CPU, m1 debug/loader) onto one data-memory port; `DMEM_ARB_RR_EN selects round-robin, else m0 fixed priority.
// Latency: gnt one cycle after req is seen in IDLE, rvalid one cycle after gnt; one write per 2 cycles, one read per 3.
// Backpressure: no handshake; a requester holds req and its command stable until its gnt pulse, and rvalid cannot be stalled.
module dmem_arbiter #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  sysclk,
  input  logic                  rst,
  input  logic                  m0_req,
  input  logic                  m0_we,
  input  logic [1:0]            m0_rw_mode,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic [DATA_WIDTH-1:0] m0_wdata,
  output logic                  m0_gnt,
  output logic                  m0_rvalid,
  output logic [DATA_WIDTH-1:0] m0_rdata,
  input  logic                  m1_req,
  input  logic                  m1_we,
  input  logic [1:0]            m1_rw_mode,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic [DATA_WIDTH-1:0] m1_wdata,
  output logic                  m1_gnt,
  output logic                  m1_rvalid,
  output logic [DATA_WIDTH-1:0] m1_rdata,
  output logic                  mem_wr_en,
  output logic [1:0]            mem_rw_mode,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ISSUE  = 2'd1;
  localparam logic [1:0] RDWAIT = 2'd2;

  logic [1:0] state_q;
  logic [1:0] state_d;
  logic       owner_q;
  logic       winner;

  logic                  own_we;
  logic [1:0]            own_rw_mode;
  logic [ADDR_WIDTH-1:0] own_addr;
  logic [DATA_WIDTH-1:0] own_wdata;

`ifdef DMEM_ARB_RR_EN
  logic rr_ptr_q;

  // Pointer moves to the non-winner on every grant, so contention alternates.
  always_ff @(posedge sysclk or negedge rst) begin
    if (!rst) begin
      rr_ptr_q <= 1'b0;
    end else if (state_q == ISSUE) begin
      rr_ptr_q <= ~owner_q;
    end
  end

  assign winner = (m0_req && m1_req) ? rr_ptr_q : m1_req;
`else
  // m1 only wins when m0 is silent; only consulted when some req is high.
  assign winner = ~m0_req;
`endif

  assign own_we      = owner_q ? m1_we      : m0_we;
  assign own_rw_mode = owner_q ? m1_rw_mode : m0_rw_mode;
  assign own_addr    = owner_q ? m1_addr    : m0_addr;
  assign own_wdata   = owner_q ? m1_wdata   : m0_wdata;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (m0_req || m1_req) state_d = ISSUE;
      ISSUE:   state_d = own_we ? IDLE : RDWAIT;
      RDWAIT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sysclk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && (m0_req || m1_req)) begin
        owner_q <= winner;
      end
    end
  end

  // All outputs decode from the registered state, so reset forces them to 0 at once.
  always_comb begin
    m0_gnt      = 1'b0;
    m1_gnt      = 1'b0;
    m0_rvalid   = 1'b0;
    m1_rvalid   = 1'b0;
    m0_rdata    = '0;
    m1_rdata    = '0;
    mem_wr_en   = 1'b0;
    mem_rw_mode = 2'b00;
    mem_addr    = '0;
    mem_wdata   = '0;
    case (state_q)
      ISSUE: begin
        mem_wr_en   = own_we;
        mem_rw_mode = own_rw_mode;
        mem_addr    = own_addr;
        mem_wdata   = own_wdata;
        m0_gnt      = ~owner_q;
        m1_gnt      = owner_q;
      end
      RDWAIT: begin
        if (owner_q) begin
          m1_rvalid = 1'b1;
          m1_rdata  = mem_rdata;
        end else begin
          m0_rvalid = 1'b1;
          m0_rdata  = mem_rdata;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a one-cycle-latency read memory model.
module tb_dmem_arbiter;
  localparam int AW = 12;
  localparam int DW = 32;

  logic          sysclk;
  logic          rst;
  logic          m0_req, m0_we, m1_req, m1_we;
  logic [1:0]    m0_rw_mode, m1_rw_mode;
  logic [AW-1:0] m0_addr, m1_addr;
  logic [DW-1:0] m0_wdata, m1_wdata;
  logic          m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
  logic [DW-1:0] m0_rdata, m1_rdata;
  logic          mem_wr_en;
  logic [1:0]    mem_rw_mode;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic [AW-1:0] rd_addr_q;

  int checks = 0;
  int errors = 0;

  dmem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .sysclk(sysclk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_rw_mode(m0_rw_mode), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_rw_mode(m1_rw_mode), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .mem_wr_en(mem_wr_en), .mem_rw_mode(mem_rw_mode), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  initial sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  // Read data appears one cycle after the address; contents are a fixed table.
  always @(posedge sysclk) rd_addr_q <= mem_addr;
  always_comb begin
    case (rd_addr_q)
      12'h004: mem_rdata = 32'h1234_5678;
      12'h020: mem_rdata = 32'hA5A5_0001;
      12'h030: mem_rdata = 32'h5A5A_0002;
      default: mem_rdata = {20'h0, rd_addr_q};
    endcase
  end

  task automatic step;
    @(posedge sysclk);
    @(negedge sysclk);
  endtask

  task automatic idle_inputs;
    m0_req = 0; m0_we = 0; m0_rw_mode = 0; m0_addr = 0; m0_wdata = 0;
    m1_req = 0; m1_we = 0; m1_rw_mode = 0; m1_addr = 0; m1_wdata = 0;
  endtask

  task automatic test_reset;
    rst = 0;
    idle_inputs();
    m0_req = 1; m0_we = 1; m0_addr = 12'h0AA; m0_wdata = 32'hFFFF_FFFF;
    step(); step();
    checks++; if ({m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, mem_wr_en} !== 5'b0) begin
      errors++; $display("FAIL reset_ctrl: got %b exp 00000", {m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, mem_wr_en}); end
    checks++; if (mem_addr !== 0 || mem_wdata !== 0 || mem_rw_mode !== 0) begin
      errors++; $display("FAIL reset_bus: addr %h wdata %h mode %b exp 0", mem_addr, mem_wdata, mem_rw_mode); end
    m0_req = 0;
    rst = 1;
    step();
    checks++; if (m0_gnt !== 0 || mem_wr_en !== 0) begin
      errors++; $display("FAIL reset_release: gnt %b wr_en %b exp 0 0", m0_gnt, mem_wr_en); end
    idle_inputs();
  endtask

  task automatic test_single_write;
    m1_req = 1; m1_we = 1; m1_rw_mode = 2'b10; m1_addr = 12'h010; m1_wdata = 32'hDEAD_BEEF;
    step();
    checks++; if (m1_gnt !== 1 || m0_gnt !== 0 || mem_wr_en !== 1) begin
      errors++; $display("FAIL wr_gnt: m1_gnt %b m0_gnt %b wr_en %b exp 1 0 1", m1_gnt, m0_gnt, mem_wr_en); end
    checks++; if (mem_addr !== 12'h010 || mem_wdata !== 32'hDEAD_BEEF || mem_rw_mode !== 2'b10) begin
      errors++; $display("FAIL wr_bus: addr %h wdata %h mode %b exp 010 deadbeef 10", mem_addr, mem_wdata, mem_rw_mode); end
    m1_req = 0;
    step();
    checks++; if (m1_gnt !== 0 || mem_wr_en !== 0 || mem_addr !== 0 || m1_rvalid !== 0) begin
      errors++; $display("FAIL wr_idle: gnt %b wr_en %b addr %h rvalid %b exp 0 0 000 0", m1_gnt, mem_wr_en, mem_addr, m1_rvalid); end
    idle_inputs();
  endtask

  task automatic test_single_read;
    m0_req = 1; m0_we = 0; m0_rw_mode = 2'b10; m0_addr = 12'h004;
    step();
    checks++; if (m0_gnt !== 1 || mem_wr_en !== 0 || mem_addr !== 12'h004) begin
      errors++; $display("FAIL rd_gnt: gnt %b wr_en %b addr %h exp 1 0 004", m0_gnt, mem_wr_en, mem_addr); end
    m0_req = 0;
    step();
    checks++; if (m0_rvalid !== 1 || m0_rdata !== 32'h1234_5678 || m0_gnt !== 0) begin
      errors++; $display("FAIL rd_data: rvalid %b rdata %h gnt %b exp 1 12345678 0", m0_rvalid, m0_rdata, m0_gnt); end
    checks++; if (m1_rvalid !== 0 || m1_rdata !== 0) begin
      errors++; $display("FAIL rd_other: m1_rvalid %b m1_rdata %h exp 0 0", m1_rvalid, m1_rdata); end
    step();
    checks++; if (m0_rvalid !== 0 || m0_rdata !== 0) begin
      errors++; $display("FAIL rd_done: rvalid %b rdata %h exp 0 0", m0_rvalid, m0_rdata); end
    idle_inputs();
  endtask

  task automatic test_reset_mid_read;
    m0_req = 1; m0_we = 0; m0_addr = 12'h004;
    step();
    m0_req = 0;
    @(posedge sysclk);
    #1 rst = 0;
    #1;
    checks++; if (m0_rvalid !== 0 || m0_rdata !== 0 || m0_gnt !== 0 || mem_wr_en !== 0 || mem_addr !== 0) begin
      errors++; $display("FAIL rst_rdwait: rvalid %b rdata %h gnt %b wr_en %b addr %h exp all 0", m0_rvalid, m0_rdata, m0_gnt, mem_wr_en, mem_addr); end
    step();
    checks++; if (m0_rvalid !== 0 || m1_rvalid !== 0) begin
      errors++; $display("FAIL rst_hold: rvalid %b %b exp 0 0", m0_rvalid, m1_rvalid); end
    rst = 1;
    step();
    checks++; if (m0_rvalid !== 0 || m0_gnt !== 0) begin
      errors++; $display("FAIL rst_after: rvalid %b gnt %b exp 0 0", m0_rvalid, m0_gnt); end
    m1_req = 1; m1_we = 1; m1_addr = 12'h011;
    step();
    checks++; if (m1_gnt !== 1 || mem_addr !== 12'h011) begin
      errors++; $display("FAIL rst_idle: m1_gnt %b addr %h exp 1 011", m1_gnt, mem_addr); end
    m1_req = 0;
    step();
    idle_inputs();
  endtask

  task automatic test_req_dropped;
    m0_req = 1; m0_we = 0; m0_addr = 12'h020;
    step();
    m0_req = 0;
    m1_req = 1; m1_we = 1; m1_addr = 12'h060;
    step();
    checks++; if (m0_rvalid !== 1 || m0_rdata !== 32'hA5A5_0001) begin
      errors++; $display("FAIL drop_rd: rvalid %b rdata %h exp 1 a5a50001", m0_rvalid, m0_rdata); end
    m1_req = 0;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++; if (m1_gnt !== 0 || mem_wr_en !== 0) begin
        errors++; $display("FAIL drop_nognt%0d: gnt %b wr_en %b exp 0 0", i, m1_gnt, mem_wr_en); end
    end
    idle_inputs();
  endtask

  task automatic test_back_to_back;
    logic exp;
    m0_req = 1; m0_we = 1; m0_addr = 12'h070; m0_wdata = 32'h0000_0070;
    for (int i = 0; i < 4; i++) begin
      step();
      exp = (i % 2 == 0);
      checks++; if (m0_gnt !== exp || mem_wr_en !== exp) begin
        errors++; $display("FAIL b2b_%0d: gnt %b wr_en %b exp %b", i, m0_gnt, mem_wr_en, exp); end
      if (i == 2) m0_req = 0;
    end
    idle_inputs();
  endtask

`ifndef DMEM_ARB_RR_EN
  task automatic test_contention_fixed;
    logic exp;
    m0_req = 1; m0_we = 1; m0_addr = 12'h100; m0_wdata = 32'h0000_00A0;
    m1_req = 1; m1_we = 1; m1_addr = 12'h200; m1_wdata = 32'h0000_00B1;
    for (int i = 0; i < 10; i++) begin
      step();
      exp = (i % 2 == 0);
      checks++; if (m0_gnt !== exp || m1_gnt !== 0) begin
        errors++; $display("FAIL fixed_%0d: m0_gnt %b m1_gnt %b exp %b 0", i, m0_gnt, m1_gnt, exp); end
      if (exp) begin
        checks++; if (mem_addr !== 12'h100 || mem_wdata !== 32'h0000_00A0) begin
          errors++; $display("FAIL fixed_bus%0d: addr %h wdata %h exp 100 000000a0", i, mem_addr, mem_wdata); end
      end
    end
    idle_inputs();
    step();
  endtask
`else
  task automatic test_contention_rr;
    int phase, own;
    rst = 0;
    step();
    rst = 1;
    m0_req = 1; m0_we = 0; m0_addr = 12'h020;
    m1_req = 1; m1_we = 0; m1_addr = 12'h030;
    for (int k = 0; k < 12; k++) begin
      step();
      phase = k % 3;
      own = (k / 3) % 2;
      checks++; if (m0_gnt !== (phase == 0 && own == 0) || m1_gnt !== (phase == 0 && own == 1)) begin
        errors++; $display("FAIL rr_gnt%0d: m0 %b m1 %b exp %b %b", k, m0_gnt, m1_gnt, (phase == 0 && own == 0), (phase == 0 && own == 1)); end
      checks++; if (m0_rvalid !== (phase == 1 && own == 0) || m1_rvalid !== (phase == 1 && own == 1)) begin
        errors++; $display("FAIL rr_rv%0d: m0 %b m1 %b exp %b %b", k, m0_rvalid, m1_rvalid, (phase == 1 && own == 0), (phase == 1 && own == 1)); end
      if (phase == 1) begin
        checks++; if ((own == 0 && (m0_rdata !== 32'hA5A5_0001 || m1_rdata !== 0)) ||
                      (own == 1 && (m1_rdata !== 32'h5A5A_0002 || m0_rdata !== 0))) begin
          errors++; $display("FAIL rr_data%0d: m0 %h m1 %h owner %0d", k, m0_rdata, m1_rdata, own); end
      end
    end
    idle_inputs();
    step();
  endtask
`endif

  initial begin
    test_reset();
    test_single_write();
    test_single_read();
    test_reset_mid_read();
    test_req_dropped();
    test_back_to_back();
`ifndef DMEM_ARB_RR_EN
    test_contention_fixed();
`else
    test_contention_rr();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
